// File: rtl/result_accum.sv
// result_accum: sums COUNT consecutive samples of the adder-chain result
// stream into one block sum and presents it on a valid/ready output.
// An early flush closes a partial block.
// Optional build macro RESULT_ACCUM_SAT_EN: the accumulator saturates at
// 2^SUM_W-1 instead of wrapping, and an extra out_sat output flags the block.
module result_accum #(
   parameter int DATA_W = 32,
   parameter int COUNT  = 4,
   parameter int SUM_W  = 34,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   output logic [SUM_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_cnt,
   input  logic              out_ready
`ifdef RESULT_ACCUM_SAT_EN
   ,
   output logic              out_sat
`endif
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t             state_q, state_d;
   logic [SUM_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]   out_sum_q, out_sum_d;
   logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

   logic               accept;
   logic [SUM_W-1:0]   add_val;
   logic [SUM_W-1:0]   sum_nx;
   logic [CNT_W-1:0]   cnt_nx;

`ifdef RESULT_ACCUM_SAT_EN
   logic               sat_q, sat_d;
   logic               out_sat_q, out_sat_d;
   logic [SUM_W:0]     sum_ext;
   logic               sat_nx;
`endif

   // In HOLD a new sample can only enter in the same cycle the held block leaves.
   assign in_ready  = (state_q == ACCUM) ? 1'b1 : out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign out_sum   = out_sum_q;
   assign out_cnt   = out_cnt_q;

   assign add_val = accept ? SUM_W'(in_data) : '0;
   assign cnt_nx  = cnt_q + CNT_W'(accept);

`ifdef RESULT_ACCUM_SAT_EN
   assign out_sat = out_sat_q;
   // Carry out of the add, or an earlier overflow in this block, pins the sum at max.
   always_comb begin
      sum_ext = {1'b0, acc_q} + {1'b0, add_val};
      sat_nx  = sat_q | sum_ext[SUM_W];
      sum_nx  = sat_nx ? '1 : sum_ext[SUM_W-1:0];
   end
`else
   assign sum_nx = acc_q + add_val;
`endif

   // Next-state: accumulate in ACCUM, close a block on COUNT or flush, drain in HOLD.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_sum_d = out_sum_q;
      out_cnt_d = out_cnt_q;
`ifdef RESULT_ACCUM_SAT_EN
      sat_d     = sat_q;
      out_sat_d = out_sat_q;
`endif
      case (state_q)
         ACCUM: begin
            // A flush coinciding with the completing sample still yields one block.
            if ((accept && cnt_nx == CNT_W'(COUNT)) || (flush && cnt_nx != '0)) begin
               state_d   = HOLD;
               out_sum_d = sum_nx;
               out_cnt_d = cnt_nx;
               acc_d     = '0;
               cnt_d     = '0;
`ifdef RESULT_ACCUM_SAT_EN
               out_sat_d = sat_nx;
               sat_d     = 1'b0;
`endif
            end else begin
               acc_d = sum_nx;
               cnt_d = cnt_nx;
`ifdef RESULT_ACCUM_SAT_EN
               sat_d = sat_nx;
`endif
            end
         end
         HOLD: begin
            // Flush is ignored here; only the output handshake moves us on.
            if (out_ready) begin
               if (accept) begin
                  if (COUNT == 1) begin
                     out_sum_d = SUM_W'(in_data);
                     out_cnt_d = CNT_W'(1);
`ifdef RESULT_ACCUM_SAT_EN
                     out_sat_d = 1'b0;
`endif
                  end else begin
                     state_d = ACCUM;
                     acc_d   = SUM_W'(in_data);
                     cnt_d   = CNT_W'(1);
                  end
               end else begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // State and datapath registers; reset drops any partial or pending block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         out_sum_q <= '0;
         out_cnt_q <= '0;
`ifdef RESULT_ACCUM_SAT_EN
         sat_q     <= 1'b0;
         out_sat_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_sum_q <= out_sum_d;
         out_cnt_q <= out_cnt_d;
`ifdef RESULT_ACCUM_SAT_EN
         sat_q     <= sat_d;
         out_sat_q <= out_sat_d;
`endif
      end
   end

endmodule

// File: tb/tb_result_accum.sv
// Bench for result_accum: directed vectors, a block-level reference model
// compared every cycle, and literal expectations for the key scenarios.
// A second instance (SUM_W=32, COUNT=2) covers wrap / saturation.
module tb_result_accum;

   localparam int DW  = 32;
   localparam int CNT = 4;
   localparam int SW  = 34;
   localparam int CW  = 3;
   localparam longint unsigned SMAX = (64'd1 << SW) - 64'd1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic          out_valid;
   logic [SW-1:0] out_sum;
   logic [CW-1:0] out_cnt;
   logic          out_ready = 1'b1;

   logic          b_in_valid = 1'b0;
   logic [31:0]   b_in_data = '0;
   logic          b_in_ready;
   logic          b_flush = 1'b0;
   logic          b_out_valid;
   logic [31:0]   b_out_sum;
   logic [1:0]    b_out_cnt;
   logic          b_out_ready = 1'b1;

`ifdef RESULT_ACCUM_SAT_EN
   logic          out_sat;
   logic          b_out_sat;
`endif

   result_accum #(.DATA_W(DW), .COUNT(CNT), .SUM_W(SW), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
      .out_sum(out_sum), .out_cnt(out_cnt), .out_ready(out_ready)
`ifdef RESULT_ACCUM_SAT_EN
      , .out_sat(out_sat)
`endif
   );

   result_accum #(.DATA_W(32), .COUNT(2), .SUM_W(32), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid),
      .out_sum(b_out_sum), .out_cnt(b_out_cnt), .out_ready(b_out_ready)
`ifdef RESULT_ACCUM_SAT_EN
      , .out_sat(b_out_sat)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the open block is a running integer sum and sample count;
   // a closed block waits as "pending" until the output handshake takes it.
   longint unsigned m_sum = 0, m_psum = 0;
   int              m_n = 0, m_pn = 0;
   bit              m_pend = 0;
   bit              m_was, m_rdy, m_acc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sum  = 0;
         m_n    = 0;
         m_pend = 0;
      end else begin
         m_was = m_pend;
         m_rdy = !m_pend || out_ready;
         m_acc = in_valid && m_rdy;
         if (m_was && out_ready) m_pend = 0;
         if (m_acc) begin
            m_sum += longint'(in_data);
            m_n++;
         end
         if (m_n == CNT || (!m_was && flush && m_n > 0)) begin
            m_pend = 1;
            m_psum = m_sum;
            m_pn   = m_n;
            m_sum  = 0;
            m_n    = 0;
         end
      end
   end

   function automatic longint unsigned exp_sum(input longint unsigned s);
`ifdef RESULT_ACCUM_SAT_EN
      return (s > SMAX) ? SMAX : s;
`else
      return s & SMAX;
`endif
   endfunction

   // Per-cycle comparison against the model, away from the clock edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_pend || out_ready)});
         chk("out_valid", {63'd0, out_valid}, {63'd0, m_pend});
         if (m_pend) begin
            chk("out_sum", {30'd0, out_sum}, exp_sum(m_psum));
            chk("out_cnt", {61'd0, out_cnt}, 64'(m_pn));
`ifdef RESULT_ACCUM_SAT_EN
            chk("out_sat", {63'd0, out_sat}, {63'd0, (m_psum > SMAX)});
`endif
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic [63:0] s, input logic [63:0] c);
      @(negedge clk);
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({name, "_sum"}, {30'd0, out_sum}, s);
      chk({name, "_cnt"}, {61'd0, out_cnt}, c);
   endtask

   initial begin
      // reset values
      #3;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_sum", {30'd0, out_sum}, 64'd0);
      chk("rst_out_cnt", {61'd0, out_cnt}, 64'd0);
`ifdef RESULT_ACCUM_SAT_EN
      chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
`endif
      #4 rst = 1'b0;
      cycle();

      // 1: full block 1,2,3,4
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(DW'(i));
      chk_out("t1", 64'd10, 64'd4);
      cycle();

      // 2: flush partial block, then flush with nothing collected
      send(DW'(5));
      send(DW'(7));
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk_out("t2", 64'd12, 64'd2);
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("t2_empty_flush", {63'd0, out_valid}, 64'd0);
      cycle();

      // flush coincident with the completing sample: one block only
      send(DW'(1)); send(DW'(2)); send(DW'(3));
      flush = 1'b1;
      send(DW'(4));
      flush = 1'b0;
      chk_out("t2_coinc", 64'd10, 64'd4);
      cycle();
      @(negedge clk);
      chk("t2_coinc_single", {63'd0, out_valid}, 64'd0);
      cycle();

      // flush with an accept at cnt==0
      flush = 1'b1;
      send(DW'(6));
      flush = 1'b0;
      chk_out("t2_flush1", 64'd6, 64'd1);
      cycle();

      // 3: backpressure, held sample 9 joins the next block without a bubble
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(DW'(1));
      in_valid = 1'b1;
      in_data  = DW'(9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_sum", {30'd0, out_sum}, 64'd4);
         chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      send(DW'(1)); send(DW'(1)); send(DW'(1));
      chk_out("t3", 64'd12, 64'd4);
      cycle();

      // 4: maximum samples without overflow at SUM_W=34
      for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF);
      chk_out("t4", 64'h3_FFFF_FFFC, 64'd4);
      cycle();

      // 5: SUM_W=32, COUNT=2 instance
      b_in_valid = 1'b1;
      b_in_data  = 32'hFFFF_FFFF;
      cycle();
      b_in_data  = 32'd2;
      cycle();
      b_in_valid = 1'b0;
      @(negedge clk);
      chk("t5_valid", {63'd0, b_out_valid}, 64'd1);
      chk("t5_cnt", {62'd0, b_out_cnt}, 64'd2);
`ifdef RESULT_ACCUM_SAT_EN
      chk("t5_sum", {32'd0, b_out_sum}, 64'hFFFF_FFFF);
      chk("t5_sat", {63'd0, b_out_sat}, 64'd1);
`else
      chk("t5_sum", {32'd0, b_out_sum}, 64'h1);
`endif
      cycle();

      // 6: async reset mid-block
      send(DW'(7)); send(DW'(8));
      #2 rst = 1'b1;
      #1;
      chk("t6_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_ready", {63'd0, in_ready}, 64'd1);
      #2 rst = 1'b0;
      for (int i = 1; i <= 4; i++) send(DW'(i));
      chk_out("t6", 64'd10, 64'd4);
      cycle();

      // async reset mid-HOLD drops the pending block at once
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(DW'(3));
      #2 rst = 1'b1;
      #1;
      chk("t6h_valid", {63'd0, out_valid}, 64'd0);
      chk("t6h_ready", {63'd0, in_ready}, 64'd1);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      send(DW'(2)); send(DW'(2)); send(DW'(2)); send(DW'(2));
      chk_out("t6h", 64'd8, 64'd4);
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
